// File: rtl/evm_multi_counter.sv
// ---------------------------------------------------------------------------
// evm_multi_counter
//
// Electronic-voting-machine core for NCAND candidates. Each ballot is armed
// by an admin press and accepts exactly one vote. Counts are packed BCD,
// NDIG digits per candidate, and saturate at all-9s with a sticky ovf flag.
// Multi-press and unauthorised presses are rejected via the invalid output.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   admin      in   ballot-authorise button (level, synchronous)
//   vote       in   NCAND candidate buttons (level, bit i = candidate i)
//   clear      in   synchronous clear of counts/ovf, honoured in IDLE only
//   ready_led  out  ballot armed
//   cast_led   out  one-hot acknowledge of accepted vote, held HOLD cycles
//   invalid    out  rejected press indication, held HOLD cycles
//   counts     out  packed BCD counts, candidate i at [(i+1)*NDIG*4-1 : i*NDIG*4]
//   ovf        out  sticky saturation flag per candidate
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for an admin press; clear honoured here
// ARMED  | ballot authorised, waiting for exactly one vote press
// CAST   | vote accepted, cast_led held for HOLD cycles, then IDLE
// INV    | press rejected, invalid held for HOLD cycles, then return state
// ---------------------------------------------------------------------------
module evm_multi_counter #(
  parameter int NCAND = 4,
  parameter int NDIG  = 3,
  parameter int HOLD  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    admin,
  input  logic [NCAND-1:0]        vote,
  input  logic                    clear,
  output logic                    ready_led,
  output logic [NCAND-1:0]        cast_led,
  output logic                    invalid,
  output logic [NCAND*NDIG*4-1:0] counts,
  output logic [NCAND-1:0]        ovf
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAST  = 2'd2,
    S_INV   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Return target for INV: 0 = IDLE, 1 = ARMED.
  logic ret_q, ret_d;

  logic [CW-1:0] hold_q, hold_d;

  logic             admin_q;
  logic [NCAND-1:0] vote_q;
  logic             admin_press;
  logic [NCAND-1:0] vote_press;
  logic             any_vote;
  logic             one_vote;

  logic [NCAND-1:0][NDIG-1:0][3:0] counts_q, counts_d;
  logic [NCAND-1:0]                ovf_q, ovf_d;
  logic [NCAND-1:0]                all_nine;

  logic             ready_q, ready_d;
  logic [NCAND-1:0] cast_q, cast_d;
  logic             inv_q, inv_d;

  // -------------------------------------------------------------------------
  // Press detection: rising edge of the live input against last cycle's sample
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      admin_q <= 1'b0;
      vote_q  <= '0;
    end else begin
      admin_q <= admin;
      vote_q  <= vote;
    end
  end

  assign admin_press = admin & ~admin_q;
  assign vote_press  = vote & ~vote_q;
  assign any_vote    = |vote_press;
  // Clearing the lowest set bit leaves zero only for a single press.
  assign one_vote    = any_vote &&
                       ((vote_press & (vote_press - NCAND'(1))) == '0);

  // -------------------------------------------------------------------------
  // FSM: state register (also holds the registered outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ret_q   <= 1'b0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      cast_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      cast_q  <= cast_d;
      inv_q   <= inv_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE: begin
        // An unauthorised vote wins over a coincident admin press: the
        // vote was made before the ballot was armed.
        if (any_vote) begin
          state_d = S_INV;
          ret_d   = 1'b0;
        end else if (admin_press) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (one_vote) begin
          state_d = S_CAST;
        end else if (any_vote) begin
          state_d = S_INV;
          ret_d   = 1'b1;
        end
      end
      S_CAST: begin
        if (hold_q == '0) state_d = S_IDLE;
      end
      S_INV: begin
        if (hold_q == '0) state_d = ret_q ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Hold timer: down-counter reloaded on every state change; the exit edge
  // is the one that sees terminal count, giving exactly HOLD cycles.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - CW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (computed from the next state, then registered)
  // -------------------------------------------------------------------------
  always_comb begin
    ready_d = (state_d == S_ARMED);
    inv_d   = (state_d == S_INV);
    cast_d  = '0;
    if (state_d == S_CAST) begin
      cast_d = (state_q == S_CAST) ? cast_q : vote_press;
    end
  end

  // -------------------------------------------------------------------------
  // BCD counters
  // -------------------------------------------------------------------------
  always_comb begin
    all_nine = '1;
    for (int c = 0; c < NCAND; c++) begin
      for (int d = 0; d < NDIG; d++) begin
        if (counts_q[c][d] != 4'd9) all_nine[c] = 1'b0;
      end
    end
  end

  always_comb begin
    logic carry;
    carry    = 1'b0;
    counts_d = counts_q;
    ovf_d    = ovf_q;
    if (state_q == S_IDLE && clear) begin
      counts_d = '0;
      ovf_d    = '0;
    end else if (state_q == S_ARMED && one_vote) begin
      for (int c = 0; c < NCAND; c++) begin
        if (vote_press[c]) begin
          if (all_nine[c]) begin
            ovf_d[c] = 1'b1;
          end else begin
            carry = 1'b1;
            for (int d = 0; d < NDIG; d++) begin
              if (carry) begin
                if (counts_q[c][d] == 4'd9) begin
                  counts_d[c][d] = 4'd0;
                end else begin
                  counts_d[c][d] = counts_q[c][d] + 4'd1;
                  carry          = 1'b0;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counts_q <= '0;
      ovf_q    <= '0;
    end else begin
      counts_q <= counts_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready_led = ready_q;
  assign cast_led  = cast_q;
  assign invalid   = inv_q;
  assign counts    = counts_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_evm_multi_counter.sv
module tb_evm_multi_counter;

  localparam int NCAND = 4;
  localparam int NDIG  = 3;
  localparam int HOLD  = 4;
  localparam int CWID  = NDIG * 4;

  logic                    clk;
  logic                    reset;
  logic                    admin;
  logic [NCAND-1:0]        vote;
  logic                    clear;
  logic                    ready_led;
  logic [NCAND-1:0]        cast_led;
  logic                    invalid;
  logic [NCAND*CWID-1:0]   counts;
  logic [NCAND-1:0]        ovf;

  int checks;
  int errors;

  evm_multi_counter #(.NCAND(NCAND), .NDIG(NDIG), .HOLD(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .admin     (admin),
    .vote      (vote),
    .clear     (clear),
    .ready_led (ready_led),
    .cast_led  (cast_led),
    .invalid   (invalid),
    .counts    (counts),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CWID-1:0] cnt(input int c);
    return counts[c*CWID +: CWID];
  endfunction

  // One complete ballot for candidate c, ending back in IDLE.
  task automatic ballot(input int c);
    admin = 1'b1; step();
    admin = 1'b0; step();
    vote = NCAND'(1) << c; step();
    vote = '0;
    repeat (HOLD) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    admin  = 1'b0;
    vote   = '0;
    clear  = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_ready", 64'(ready_led), 64'd0);
    chk("rst_cast", 64'(cast_led), 64'd0);
    chk("rst_inv", 64'(invalid), 64'd0);
    chk("rst_counts", 64'(counts), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b1;
    step();

    // Admin then vote[1]
    admin = 1'b1; step();
    chk("arm_ready", 64'(ready_led), 64'd1);
    admin = 1'b0; step();
    vote = 4'b0010; step();
    vote = 4'b0000;
    chk("cast1_led", 64'(cast_led), 64'h2);
    chk("cast1_cnt", 64'(cnt(1)), 64'h001);
    chk("cast1_ready", 64'(ready_led), 64'd0);
    for (int i = 1; i < HOLD; i++) begin
      step();
      chk("cast1_hold", 64'(cast_led), 64'h2);
    end
    step();
    chk("cast1_end", 64'(cast_led), 64'h0);

    // Unauthorised vote in IDLE
    vote = 4'b0001; step();
    vote = 4'b0000;
    chk("unauth_inv", 64'(invalid), 64'd1);
    for (int i = 1; i < HOLD; i++) begin
      step();
      chk("unauth_hold", 64'(invalid), 64'd1);
      chk("unauth_ready", 64'(ready_led), 64'd0);
    end
    step();
    chk("unauth_end", 64'(invalid), 64'd0);
    chk("unauth_ready_end", 64'(ready_led), 64'd0);
    chk("unauth_counts", 64'(counts), 64'h000000001000);

    // Double press while armed, then retry
    admin = 1'b1; step();
    admin = 1'b0; step();
    vote = 4'b0101; step();
    vote = 4'b0000;
    chk("multi_inv", 64'(invalid), 64'd1);
    chk("multi_ready", 64'(ready_led), 64'd0);
    repeat (HOLD - 1) step();
    chk("multi_inv_last", 64'(invalid), 64'd1);
    step();
    chk("multi_ret_ready", 64'(ready_led), 64'd1);
    chk("multi_ret_inv", 64'(invalid), 64'd0);
    vote = 4'b0100; step();
    vote = 4'b0000;
    chk("retry_cast", 64'(cast_led), 64'h4);
    repeat (HOLD) step();
    chk("retry_c2", 64'(cnt(2)), 64'h001);
    chk("retry_c0", 64'(cnt(0)), 64'h000);

    // Held vote button counts once
    admin = 1'b1; step();
    admin = 1'b0; step();
    vote = 4'b0010; step();
    chk("held_c1", 64'(cnt(1)), 64'h002);
    repeat (HOLD) step();
    admin = 1'b1; step();
    admin = 1'b0;
    chk("held_arm", 64'(ready_led), 64'd1);
    repeat (3) step();
    chk("held_still_armed", 64'(ready_led), 64'd1);
    chk("held_c1_once", 64'(cnt(1)), 64'h002);
    vote = 4'b0000; step();

    // Admin press during CAST ignored
    vote = 4'b1000; step();
    vote = 4'b0000;
    chk("c3_cast", 64'(cast_led), 64'h8);
    admin = 1'b1; step();
    admin = 1'b0;
    repeat (HOLD - 1) step();
    chk("cast_admin_idle", 64'(ready_led), 64'd0);
    step();
    chk("cast_admin_lost", 64'(ready_led), 64'd0);
    chk("c3_one", 64'(cnt(3)), 64'h001);

    // Clear ignored in ARMED, honoured in IDLE
    admin = 1'b1; step();
    admin = 1'b0;
    clear = 1'b1; step();
    clear = 1'b0;
    chk("clr_armed_counts", 64'(counts), 64'h001001002000);
    vote = 4'b0001; step();
    vote = 4'b0000;
    repeat (HOLD) step();
    chk("c0_one", 64'(cnt(0)), 64'h001);
    clear = 1'b1; step();
    clear = 1'b0;
    chk("clr_idle_counts", 64'(counts), 64'h0);
    chk("clr_idle_ovf", 64'(ovf), 64'h0);

    // BCD rollover and saturation on candidate 3
    repeat (9) ballot(3);
    chk("bcd_9", 64'(cnt(3)), 64'h009);
    ballot(3);
    chk("bcd_10", 64'(cnt(3)), 64'h010);
    repeat (89) ballot(3);
    chk("bcd_99", 64'(cnt(3)), 64'h099);
    ballot(3);
    chk("bcd_100", 64'(cnt(3)), 64'h100);
    repeat (899) ballot(3);
    chk("bcd_999", 64'(cnt(3)), 64'h999);
    chk("bcd_999_ovf", 64'(ovf), 64'h0);
    admin = 1'b1; step();
    admin = 1'b0; step();
    vote = 4'b1000; step();
    vote = 4'b0000;
    chk("sat_cast", 64'(cast_led), 64'h8);
    chk("sat_cnt", 64'(cnt(3)), 64'h999);
    chk("sat_ovf", 64'(ovf), 64'h8);
    chk("sat_others", 64'(counts[3*CWID-1:0]), 64'h0);
    repeat (HOLD) step();

    // Asynchronous reset mid-CAST
    admin = 1'b1; step();
    admin = 1'b0; step();
    vote = 4'b0001; step();
    vote = 4'b0000;
    chk("pre_rst_cast", 64'(cast_led), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_cast", 64'(cast_led), 64'h0);
    chk("arst_counts", 64'(counts), 64'h0);
    chk("arst_ovf", 64'(ovf), 64'h0);
    chk("arst_ready", 64'(ready_led), 64'd0);
    chk("arst_inv", 64'(invalid), 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_ready", 64'(ready_led), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
